mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM stage of the 5-stage pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Consumes the EX/MEM register outputs (result, write enable, write address) plus the memory-control fields.
- Drives the data-RAM request/acknowledge handshake, aligns and extends load data, and generates store byte enables.
- Asserts a stall request to freeze the upstream stages while an access is outstanding.

Parameters:
- ADDR_WIDTH, 32, data/address bus width (matches `DATA_BUS_WIDTH).
- REG_ADDR_WIDTH, 5, register-file address width (matches `REG_ADDR_BUS_WIDTH).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- mem_en_in  in  1  instruction performs a memory access.
- mem_write_in  in  1  1 = store, 0 = load.
- mem_size_in  in  2  00 byte, 01 half, 10/11 word.
- mem_sign_in  in  1  sign-extend load data.
- result_in  in  32  ALU result. It is the effective address for memory ops and the write-back value otherwise.
- mem_wdata_in  in  32  store data (right-aligned).
- write_reg_en_in  in  1  register write enable from EX/MEM.
- write_reg_addr_in  in  5  destination register.
- ram_req  out  1  access request.
- ram_we  out  1  write strobe.
- ram_addr  out  32  word-aligned address ({result_in[31:2],2'b00}).
- ram_wsel  out  4  byte enables.
- ram_wdata  out  32  lane-replicated store data.
- ram_ack  in  1  access complete; load data is valid in the same cycle.
- ram_rdata  in  32  load data.
- result_out  out  32  value to MEM/WB.
- write_reg_en_out  out  1  write enable to MEM/WB.
- write_reg_addr_out  out  5  destination to MEM/WB.
- stall_req  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- addr_exc_out  out  1  misaligned-address flag (see Optional Feature).

Behaviour:
- State machine states:
  - IDLE: no access in progress.
  - BUSY: request issued, waiting for ram_ack.
  - DONE: access complete, load data held in rdata_q.
- State register and rdata_q (32b) update on posedge clk.
- When rst==0:
  - State goes to IDLE and rdata_q clears to 0.
  - ram_req, stall_req and write_reg_en_out are forced to 0 combinationally during the reset cycle.
- Request and stall:
  - ram_req = (IDLE && mem_en_in) || BUSY.
  - stall_req = ram_req.
  - ram_we = ram_req && mem_write_in.
- Transitions:
  - IDLE with mem_en_in: on ram_ack go to DONE; otherwise go to BUSY.
  - IDLE without mem_en_in: stay in IDLE.
  - BUSY: on ram_ack go to DONE; otherwise stay in BUSY.
  - DONE: go to IDLE unconditionally.
- Load data capture: on ram_ack with a load, rdata_q <= ram_rdata.
- Minimum cost of a memory instruction is 2 cycles (ack in the request cycle). Each wait cycle adds 1.
- In DONE, ram_req = 0 and stall_req = 0. The pipeline advances at the end of DONE, and the EX/MEM register presents the next instruction in IDLE.
- While stall_req = 1, write_reg_en_out = 0 (a bubble into MEM/WB). result_out and write_reg_addr_out pass through.
- Non-memory instruction in IDLE: result_out = result_in, write enable and address pass through, zero added latency.
- Load in DONE:
  - Offset off = result_in[1:0].
  - Byte: rdata_q[8*off+:8], sign- or zero-extended per mem_sign_in.
  - Half: rdata_q[16*off[1]+:16], extended the same way.
  - Word: rdata_q unchanged.
  - Store in DONE: result_out = result_in, and write_reg_en_out passes through (the decoder clears it for stores).
- Store byte enables (ram_wsel):
  - Byte: 4'b0001<<off.
  - Half: 4'b0011<<(2*off[1]).
  - Word: 4'b1111.
  - ram_wsel = 0 when ram_req = 0.
- Store data (ram_wdata):
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: wdata.
- Boundary cases:
  - ram_ack while in IDLE without a request, or in DONE, is ignored.
  - Reset while in BUSY aborts the access; the late ack is ignored.
  - Back-to-back memory instructions each pass through DONE.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- When defined:
  - A half access with off[0]==1, or a word access with off!=0, is misaligned.
  - Misaligned accesses suppress ram_req and stall_req, and the FSM stays in IDLE.
  - addr_exc_out = 1 for that cycle, and write_reg_en_out is forced to 0.
- When undefined:
  - addr_exc_out is tied to 0.
  - Low address bits beyond the access size are ignored: half uses off[1], word uses no offset bits.

Test Plan:
- ALU op result_in=0x1234, write_reg_en_in=1, addr=7 -> same cycle result_out=0x1234, write_reg_en_out=1, stall_req=0, ram_req=0.
- Load word at 0x100, ram_ack in the request cycle with rdata=0xDEADBEEF -> 1 stall cycle with write_reg_en_out=0, next cycle result_out=0xDEADBEEF, stall_req=0.
- Signed load byte at 0x103, ack after 3 wait cycles, rdata=0x80FF0102 -> stall_req high for 4 cycles, then result_out=0xFFFFFF80. The unsigned variant gives 0x00000080.
- Store half at 0x202, wdata=0xABCD, ack immediate -> ram_we=1, ram_addr=0x200, ram_wsel=4'b1100, ram_wdata=0xABCDABCD.
- Load in BUSY, rst=0 for 1 cycle, then ram_ack -> ram_req and stall_req 0 during reset, FSM in IDLE, late ack leaves rdata_q=0.
- With MEM_ALIGN_CHECK_EN, load word at 0x102 -> ram_req=0, addr_exc_out=1, write_reg_en_out=0, no stall.

Source files
------------

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : MEM pipeline stage. Runs the data-RAM req/ack handshake, builds
//            store byte enables and lane-replicated store data, aligns and
//            extends load data, and requests a pipeline stall while an access
//            is outstanding.
// Options  : MEM_ALIGN_CHECK_EN - flag misaligned half/word accesses on
//            addr_exc_out and suppress the request instead of issuing it.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_en_in,
  input  logic                      mem_write_in,
  input  logic [1:0]                mem_size_in,
  input  logic                      mem_sign_in,
  input  logic [ADDR_WIDTH-1:0]     result_in,
  input  logic [ADDR_WIDTH-1:0]     mem_wdata_in,
  input  logic                      write_reg_en_in,
  input  logic [REG_ADDR_WIDTH-1:0] write_reg_addr_in,
  output logic                      ram_req,
  output logic                      ram_we,
  output logic [ADDR_WIDTH-1:0]     ram_addr,
  output logic [3:0]                ram_wsel,
  output logic [ADDR_WIDTH-1:0]     ram_wdata,
  input  logic                      ram_ack,
  input  logic [ADDR_WIDTH-1:0]     ram_rdata,
  output logic [ADDR_WIDTH-1:0]     result_out,
  output logic                      write_reg_en_out,
  output logic [REG_ADDR_WIDTH-1:0] write_reg_addr_out,
  output logic                      stall_req,
  output logic                      addr_exc_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   rdata_q;
  logic [1:0]              off;
  logic                    misaligned;
  logic [3:0]              wsel_raw;
  logic [7:0]              load_byte;
  logic [15:0]             load_half;
  logic [ADDR_WIDTH-1:0]   load_val;

  assign off = result_in[1:0];

`ifdef MEM_ALIGN_CHECK_EN
  // Only meaningful for a new access presented in IDLE; the FSM never leaves
  // IDLE for a misaligned access, so BUSY/DONE never see one.
  assign misaligned = rst && (state == IDLE) && mem_en_in &&
                      (((mem_size_in == 2'b01) && off[0]) ||
                       (mem_size_in[1] && (off != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif
  assign addr_exc_out = misaligned;

  // State register and captured load data; reset aborts any pending access.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      rdata_q <= '0;
    end else begin
      state <= state_next;
      if (ram_req && ram_ack && !mem_write_in)
        rdata_q <= ram_rdata;
    end
  end

  // Next-state and request generation; ack outside a request is ignored.
  always_comb begin
    state_next = state;
    ram_req    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_en_in && !misaligned) begin
          ram_req    = 1'b1;
          state_next = ram_ack ? DONE : BUSY;
        end
      end
      BUSY: begin
        ram_req = 1'b1;
        if (ram_ack) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (!rst) ram_req = 1'b0;
  end

  assign stall_req = ram_req;
  assign ram_we    = ram_req && mem_write_in;
  assign ram_addr  = {result_in[ADDR_WIDTH-1:2], 2'b00};

  // Byte enables by access size; low offset bits beyond the size are ignored.
  always_comb begin
    wsel_raw = 4'b1111;
    case (mem_size_in)
      2'b00:   wsel_raw = 4'b0001 << off;
      2'b01:   wsel_raw = off[1] ? 4'b1100 : 4'b0011;
      default: wsel_raw = 4'b1111;
    endcase
  end

  assign ram_wsel = ram_req ? wsel_raw : 4'b0000;

  // Store data replicated across every lane so the RAM picks it by enable.
  always_comb begin
    ram_wdata = mem_wdata_in;
    case (mem_size_in)
      2'b00:   ram_wdata = {(ADDR_WIDTH/8){mem_wdata_in[7:0]}};
      2'b01:   ram_wdata = {(ADDR_WIDTH/16){mem_wdata_in[15:0]}};
      default: ram_wdata = mem_wdata_in;
    endcase
  end

  // Extract the addressed lane from the captured word and extend it.
  always_comb begin
    load_byte = rdata_q[8*off +: 8];
    load_half = rdata_q[16*off[1] +: 16];
    case (mem_size_in)
      2'b00:   load_val = {{(ADDR_WIDTH-8){mem_sign_in & load_byte[7]}}, load_byte};
      2'b01:   load_val = {{(ADDR_WIDTH-16){mem_sign_in & load_half[15]}}, load_half};
      default: load_val = rdata_q;
    endcase
  end

  // Load results appear in DONE; everything else passes straight through.
  always_comb begin
    result_out         = result_in;
    write_reg_addr_out = write_reg_addr_in;
    write_reg_en_out   = rst && write_reg_en_in && !stall_req && !misaligned;
    if ((state == DONE) && mem_en_in && !mem_write_in)
      result_out = load_val;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Directed self-checking bench for mem_stage. Inputs change 1ns
//            after the rising edge; outputs are checked on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en_in, mem_write_in, mem_sign_in;
  logic [1:0]  mem_size_in;
  logic [31:0] result_in, mem_wdata_in;
  logic        write_reg_en_in;
  logic [4:0]  write_reg_addr_in;
  logic        ram_req, ram_we, ram_ack;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_wsel;
  logic [31:0] result_out;
  logic        write_reg_en_out;
  logic [4:0]  write_reg_addr_out;
  logic        stall_req, addr_exc_out;

  int vectors = 0;
  int errors  = 0;

  mem_stage #(.ADDR_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .mem_en_in(mem_en_in), .mem_write_in(mem_write_in),
    .mem_size_in(mem_size_in), .mem_sign_in(mem_sign_in),
    .result_in(result_in), .mem_wdata_in(mem_wdata_in),
    .write_reg_en_in(write_reg_en_in), .write_reg_addr_in(write_reg_addr_in),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wsel(ram_wsel), .ram_wdata(ram_wdata),
    .ram_ack(ram_ack), .ram_rdata(ram_rdata),
    .result_out(result_out), .write_reg_en_out(write_reg_en_out),
    .write_reg_addr_out(write_reg_addr_out),
    .stall_req(stall_req), .addr_exc_out(addr_exc_out)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic en, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] res,
                        input logic [31:0] wd, input logic wen);
    mem_en_in = en; mem_write_in = wr; mem_size_in = sz; mem_sign_in = sg;
    result_in = res; mem_wdata_in = wd; write_reg_en_in = wen;
  endtask

  task automatic test_reset();
    rst = 1'b0; ram_ack = 1'b0; ram_rdata = 32'h0; write_reg_addr_in = 5'd3;
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1);
    @(negedge clk);
    vectors++;
    if (ram_req !== 1'b0 || stall_req !== 1'b0 || write_reg_en_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b stall=%b wen=%b, want 0 0 0", ram_req, stall_req, write_reg_en_out);
    end
    next_cycle();
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic test_alu_passthrough();
    write_reg_addr_in = 5'd7;
    set_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h1234, 32'h0, 1'b1);
    @(negedge clk);
    vectors++;
    if (result_out !== 32'h1234 || write_reg_en_out !== 1'b1 || write_reg_addr_out !== 5'd7 ||
        stall_req !== 1'b0 || ram_req !== 1'b0) begin
      errors++;
      $display("FAIL alu_pass: res=%h wen=%b addr=%0d stall=%b req=%b, want 1234 1 7 0 0",
               result_out, write_reg_en_out, write_reg_addr_out, stall_req, ram_req);
    end
    next_cycle();
  endtask

  task automatic test_load_word();
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1);
    ram_ack = 1'b1; ram_rdata = 32'hDEADBEEF;
    @(negedge clk);
    vectors++;
    if (stall_req !== 1'b1 || ram_req !== 1'b1 || ram_we !== 1'b0 ||
        write_reg_en_out !== 1'b0 || ram_addr !== 32'h100) begin
      errors++;
      $display("FAIL lw_request: stall=%b req=%b we=%b wen=%b addr=%h, want 1 1 0 0 100",
               stall_req, ram_req, ram_we, write_reg_en_out, ram_addr);
    end
    next_cycle();
    ram_ack = 1'b0; ram_rdata = 32'h0;
    @(negedge clk);
    vectors++;
    if (result_out !== 32'hDEADBEEF || stall_req !== 1'b0 || write_reg_en_out !== 1'b1) begin
      errors++;
      $display("FAIL lw_done: res=%h stall=%b wen=%b, want deadbeef 0 1", result_out, stall_req, write_reg_en_out);
    end
    next_cycle();
  endtask

  // Ack arrives in the 4th request cycle: 4 stall cycles, then DONE.
  task automatic test_load_byte_wait(input logic sg, input logic [31:0] exp);
    set_op(1'b1, 1'b0, 2'b00, sg, 32'h103, 32'h0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      ram_ack   = (c == 3);
      ram_rdata = (c == 3) ? 32'h80FF0102 : 32'h0;
      @(negedge clk);
      vectors++;
      if (stall_req !== 1'b1 || write_reg_en_out !== 1'b0) begin
        errors++;
        $display("FAIL lb_wait_%0d sign=%b: stall=%b wen=%b, want 1 0", c, sg, stall_req, write_reg_en_out);
      end
      next_cycle();
    end
    ram_ack = 1'b0;
    @(negedge clk);
    vectors++;
    if (result_out !== exp || stall_req !== 1'b0 || write_reg_en_out !== 1'b1) begin
      errors++;
      $display("FAIL lb_done sign=%b: res=%h stall=%b wen=%b, want %h 0 1", sg, result_out, stall_req, write_reg_en_out, exp);
    end
    next_cycle();
  endtask

  task automatic test_load_half_signed();
    set_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 1'b1);
    ram_ack = 1'b1; ram_rdata = 32'h80011234;
    next_cycle();
    ram_ack = 1'b0;
    @(negedge clk);
    vectors++;
    if (result_out !== 32'hFFFF8001) begin
      errors++;
      $display("FAIL lh_signed: res=%h, want ffff8001", result_out);
    end
    next_cycle();
  endtask

  task automatic test_stores();
    logic [31:0] addr_t [3]  = '{32'h202, 32'h301, 32'h400};
    logic [1:0]  size_t [3]  = '{2'b01, 2'b00, 2'b10};
    logic [31:0] wd_t [3]    = '{32'h0000ABCD, 32'h1234005A, 32'hCAFEF00D};
    logic [31:0] eaddr_t [3] = '{32'h200, 32'h300, 32'h400};
    logic [3:0]  esel_t [3]  = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] ewd_t [3]   = '{32'hABCDABCD, 32'h5A5A5A5A, 32'hCAFEF00D};
    for (int i = 0; i < 3; i++) begin
      set_op(1'b1, 1'b1, size_t[i], 1'b0, addr_t[i], wd_t[i], 1'b0);
      ram_ack = 1'b1;
      @(negedge clk);
      vectors++;
      if (ram_we !== 1'b1 || ram_addr !== eaddr_t[i] || ram_wsel !== esel_t[i] || ram_wdata !== ewd_t[i]) begin
        errors++;
        $display("FAIL store_%0d: we=%b addr=%h wsel=%b wdata=%h, want 1 %h %b %h",
                 i, ram_we, ram_addr, ram_wsel, ram_wdata, eaddr_t[i], esel_t[i], ewd_t[i]);
      end
      next_cycle();
      @(negedge clk);
      vectors++;
      if (ram_req !== 1'b0 || ram_wsel !== 4'b0000 || ram_we !== 1'b0 || result_out !== addr_t[i] || stall_req !== 1'b0) begin
        errors++;
        $display("FAIL store_done_%0d: req=%b wsel=%b we=%b res=%h stall=%b, want 0 0000 0 %h 0",
                 i, ram_req, ram_wsel, ram_we, result_out, stall_req, addr_t[i]);
      end
      next_cycle();
    end
    ram_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);
    ram_ack = 1'b1; ram_rdata = 32'h11223344;
    next_cycle();
    ram_rdata = 32'h99999999;
    @(negedge clk);
    vectors++;
    if (result_out !== 32'h11223344 || ram_req !== 1'b0 || stall_req !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first_done: res=%h req=%b stall=%b, want 11223344 0 0", result_out, ram_req, stall_req);
    end
    next_cycle();
    set_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b1);
    ram_rdata = 32'h0000AB00;
    @(negedge clk);
    vectors++;
    if (ram_req !== 1'b1 || stall_req !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_req: req=%b stall=%b, want 1 1", ram_req, stall_req);
    end
    next_cycle();
    ram_ack = 1'b0;
    @(negedge clk);
    vectors++;
    if (result_out !== 32'h000000AB || stall_req !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_done: res=%h stall=%b, want 000000ab 0", result_out, stall_req);
    end
    next_cycle();
  endtask

  task automatic test_reset_abort();
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1);
    ram_ack = 1'b0;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (ram_req !== 1'b0 || stall_req !== 1'b0) begin
      errors++;
      $display("FAIL abort_in_reset: req=%b stall=%b, want 0 0", ram_req, stall_req);
    end
    next_cycle();
    rst = 1'b1;
    set_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1);
    ram_ack = 1'b1; ram_rdata = 32'h55555555;
    @(negedge clk);
    vectors++;
    if (ram_req !== 1'b0 || stall_req !== 1'b0 || result_out !== 32'h100) begin
      errors++;
      $display("FAIL abort_late_ack: req=%b stall=%b res=%h, want 0 0 100", ram_req, stall_req, result_out);
    end
    next_cycle();
    ram_ack = 1'b0;
    @(negedge clk);
    vectors++;
    if (dut.rdata_q !== 32'h0) begin
      errors++;
      $display("FAIL abort_rdata: rdata_q=%h, want 00000000", dut.rdata_q);
    end
    next_cycle();
  endtask

  task automatic test_alignment();
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 1'b1);
    ram_ack = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    @(negedge clk);
    vectors++;
    if (ram_req !== 1'b0 || addr_exc_out !== 1'b1 || write_reg_en_out !== 1'b0 || stall_req !== 1'b0) begin
      errors++;
      $display("FAIL align_exc: req=%b exc=%b wen=%b stall=%b, want 0 1 0 0", ram_req, addr_exc_out, write_reg_en_out, stall_req);
    end
    next_cycle();
    set_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    vectors++;
    if (addr_exc_out !== 1'b0 || ram_req !== 1'b0) begin
      errors++;
      $display("FAIL align_clear: exc=%b req=%b, want 0 0", addr_exc_out, ram_req);
    end
    next_cycle();
`else
    ram_ack = 1'b1; ram_rdata = 32'h0BADF00D;
    @(negedge clk);
    vectors++;
    if (ram_req !== 1'b1 || addr_exc_out !== 1'b0 || ram_addr !== 32'h100) begin
      errors++;
      $display("FAIL noalign_req: req=%b exc=%b addr=%h, want 1 0 100", ram_req, addr_exc_out, ram_addr);
    end
    next_cycle();
    ram_ack = 1'b0;
    @(negedge clk);
    vectors++;
    if (result_out !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL noalign_data: res=%h, want 0badf00d", result_out);
    end
    next_cycle();
`endif
  endtask

  initial begin
    test_reset();
    test_alu_passthrough();
    test_load_word();
    test_load_byte_wait(1'b1, 32'hFFFFFF80);
    test_load_byte_wait(1'b0, 32'h00000080);
    test_load_half_signed();
    test_stores();
    test_back_to_back();
    test_reset_abort();
    test_alignment();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
